// File: rtl/pulse_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package  : pulse_rx_pkg
// Brief    : Shared types, default parameters and width helper for the
//            pulse-width-coded message receiver.
// Revision : 1.0
// ============================================================================
package pulse_rx_pkg;

    localparam int c_DEF_MSG_BITS    = 24;
    localparam int c_DEF_BIT_THRESH  = 26;
    localparam int c_DEF_MAX_HIGH    = 60;
    localparam int c_DEF_GAP_TIMEOUT = 63;
    localparam int c_DEF_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } rx_state_t;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : pulse_rx_pkg
`default_nettype wire

// File: rtl/msg_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : msg_fifo
// Brief    : Synchronous FIFO; a pop frees the slot for a same-cycle push.
// Revision : 1.0
// ============================================================================
module msg_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (count == c_CNT_W'(DEPTH));
    assign head_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
                r_wr_ptr                  <= r_wr_ptr + c_CNT_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_CNT_W'(1);
            end
        end
    end

endmodule : msg_fifo
`default_nettype wire

// File: rtl/pulse_msg_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pulse_msg_receiver
// Brief    : Decodes long/short high pulses into fixed-length messages and
//            buffers them behind a valid/ready interface.
// Revision : 1.0
// ============================================================================
module pulse_msg_receiver
    import pulse_rx_pkg::*;
#(
    parameter int MSG_BITS    = c_DEF_MSG_BITS,
    parameter int BIT_THRESH  = c_DEF_BIT_THRESH,
    parameter int MAX_HIGH    = c_DEF_MAX_HIGH,
    parameter int GAP_TIMEOUT = c_DEF_GAP_TIMEOUT,
    parameter int FIFO_DEPTH  = c_DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          line_in,
    output logic [MSG_BITS-1:0]           msg_data,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int c_HI_W  = cnt_width(MAX_HIGH + 1);
    localparam int c_LO_W  = cnt_width(GAP_TIMEOUT);
    localparam int c_BIT_W = cnt_width(MSG_BITS);

    localparam logic [c_HI_W-1:0]  c_HI_SAT   = c_HI_W'(MAX_HIGH + 1);
    localparam logic [c_HI_W-1:0]  c_HI_MAX   = c_HI_W'(MAX_HIGH);
    localparam logic [c_HI_W-1:0]  c_HI_THR   = c_HI_W'(BIT_THRESH);
    localparam logic [c_LO_W-1:0]  c_LO_LAST  = c_LO_W'(GAP_TIMEOUT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(MSG_BITS - 1);

    logic                 r_sync1;
    logic                 r_line_s;
    logic                 r_line_prev;
    rx_state_t            r_state;
    rx_state_t            w_state_n;
    logic [c_HI_W-1:0]    r_hi_cnt;
    logic [c_HI_W-1:0]    w_hi_n;
    logic [c_LO_W-1:0]    r_lo_cnt;
    logic [c_LO_W-1:0]    w_lo_n;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_cnt_n;
    logic [MSG_BITS-1:0]  r_shift;
    logic [MSG_BITS-1:0]  w_shift_n;
    logic [MSG_BITS-1:0]  w_shifted;
    logic                 r_frame_err;
    logic                 r_overflow;
    logic                 w_rise;
    logic                 w_bit;
    logic                 w_push;
    logic                 w_err;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

    assign w_rise    = r_line_s & ~r_line_prev;
    assign w_bit     = (r_hi_cnt > c_HI_THR);
    assign w_shifted = {r_shift[MSG_BITS-2:0], w_bit};
    assign msg_valid = ~w_empty;
    assign w_pop     = msg_valid & msg_ready;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_line_s    <= 1'b0;
            r_line_prev <= 1'b0;
        end else begin
            r_sync1     <= line_in;
            r_line_s    <= r_sync1;
            r_line_prev <= r_line_s;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_hi_n      = r_hi_cnt;
        w_lo_n      = r_lo_cnt;
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_push      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_n = HIGH;
                    w_hi_n    = c_HI_W'(1);
                end
            end
            HIGH: begin
                if (r_line_s) begin
                    if (r_hi_cnt != c_HI_SAT) begin
                        w_hi_n = r_hi_cnt + c_HI_W'(1);
                    end
                end else if (r_hi_cnt > c_HI_MAX) begin
                    w_err       = 1'b1;
                    w_bit_cnt_n = '0;
                    w_state_n   = IDLE;
                end else begin
                    // First low cycle after the pulse: decide and shift the bit.
                    w_shift_n = w_shifted;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_push      = 1'b1;
                        w_bit_cnt_n = '0;
                        w_state_n   = IDLE;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + c_BIT_W'(1);
                        w_lo_n      = c_LO_W'(1);
                        w_state_n   = LOW;
                    end
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_n = HIGH;
                    w_hi_n    = c_HI_W'(1);
                end else begin
                    w_lo_n = r_lo_cnt + c_LO_W'(1);
                    if (r_lo_cnt == c_LO_LAST) begin
                        w_err       = 1'b1;
                        w_bit_cnt_n = '0;
                        w_state_n   = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hi_cnt    <= '0;
            r_lo_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_hi_cnt    <= w_hi_n;
            r_lo_cnt    <= w_lo_n;
            r_bit_cnt   <= w_bit_cnt_n;
            r_shift     <= w_shift_n;
            r_frame_err <= w_err;
            // A same-cycle pop makes room, so only an unrelieved full FIFO drops.
            r_overflow  <= w_push & w_full & ~w_pop;
        end
    end

    msg_fifo #(
        .WIDTH (MSG_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_shifted),
        .full      (w_full),
        .pop       (msg_ready),
        .head_data (msg_data),
        .empty     (w_empty),
        .count     (fifo_count)
    );

endmodule : pulse_msg_receiver
`default_nettype wire

// File: tb/tb_pulse_msg_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pulse_msg_receiver
// Brief    : Self-checking bench for pulse_msg_receiver (default parameters).
// Revision : 1.0
// ============================================================================
module tb_pulse_msg_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        line_in = 1'b0;
    logic        msg_ready = 1'b0;
    logic [23:0] msg_data;
    logic        msg_valid;
    logic [1:0]  fifo_count;
    logic        overflow;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;

    logic [23:0] sb[$];

    typedef struct {
        logic [23:0] data;
        int          hi1;
        int          hi0;
        int          gap;
        int          tail;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    pulse_msg_receiver dut (
        .clock      (clock),
        .reset      (reset),
        .line_in    (line_in),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    // Pulse counters and pop scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_err) n_ferr++;
            if (overflow)  n_ovf++;
            if (msg_valid && msg_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got %06h, expected no message", msg_data);
                end else begin
                    logic [23:0] exp_d;
                    exp_d = sb.pop_front();
                    if (msg_data !== exp_d) begin
                        n_fail++;
                        $display("FAIL pop_data: got %06h, expected %06h", msg_data, exp_d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // MSB first; line is left low right after the last pulse falls.
    task automatic send_bits(input logic [31:0] d, input int n, input int hi1,
                             input int hi0, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            line_in = 1'b1;
            repeat (d[i] ? hi1 : hi0) tick();
            line_in = 1'b0;
            if (i != 0) repeat (gap) tick();
        end
    endtask

    task automatic send_msg(input logic [23:0] d);
        send_bits({8'h00, d}, 24, 40, 12, 12);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        vecs[0] = '{24'hA5C3F0, 40, 12, 12, 6};
        vecs[1] = '{24'h5A5A5A, 27, 26, 12, 6};
        vecs[2] = '{24'hFFFFFF, 60,  1,  5, 6};
        vecs[3] = '{24'h000000, 27,  1, 62, 6};
        vecs[4] = '{24'h123456, 30, 10,  1, 1};
        vecs[5] = '{24'hC3A5E7, 45,  3,  3, 6};

        repeat (3) tick();
        @(negedge clock);
        chk("rst_valid", msg_valid, 0);
        chk("rst_data", msg_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Push latency with the consumer stalled.
        sb.push_back(24'hA5C3F0);
        send_msg(24'hA5C3F0);
        repeat (3) @(negedge clock);
        chk("lat_valid_early", msg_valid, 0);
        @(negedge clock);
        chk("lat_valid", msg_valid, 1);
        chk("lat_data", msg_data, 24'hA5C3F0);
        chk("lat_count", fifo_count, 1);
        tick();
        msg_ready = 1'b1;
        wait_drain();
        msg_ready = 1'b0;
        repeat (5) tick();

        // Table of pulse shapes, consumer always ready.
        msg_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].data);
            send_bits({8'h00, vecs[v].data}, 24, vecs[v].hi1, vecs[v].hi0, vecs[v].gap);
            repeat (vecs[v].tail) tick();
        end
        wait_drain();
        repeat (5) tick();
        chk("vec_no_ferr", n_ferr, 0);
        chk("vec_no_ovf", n_ovf, 0);
        msg_ready = 1'b0;

        // 61-cycle pulse is a framing error.
        send_bits(32'h1, 1, 61, 0, 0);
        repeat (10) tick();
        chk("long_ferr", n_ferr, 1);
        chk("long_count", fifo_count, 0);
        chk("long_valid", msg_valid, 0);

        // Partial message aborted by a long gap.
        send_bits(32'h2B5, 10, 40, 12, 12);
        repeat (75) tick();
        chk("gap_ferr", n_ferr, 2);
        chk("gap_count", fifo_count, 0);
        msg_ready = 1'b1;
        sb.push_back(24'h000001);
        send_msg(24'h000001);
        repeat (6) tick();
        wait_drain();
        msg_ready = 1'b0;

        // Overflow on the third message.
        sb.push_back(24'h111111);
        sb.push_back(24'h222222);
        send_msg(24'h111111);
        repeat (5) tick();
        send_msg(24'h222222);
        repeat (5) tick();
        send_msg(24'h333333);
        repeat (8) tick();
        chk("ovf_count", fifo_count, 2);
        chk("ovf_pulses", n_ovf, 1);
        chk("ovf_head", msg_data, 24'h111111);
        msg_ready = 1'b1;
        wait_drain();
        msg_ready = 1'b0;
        tick();
        chk("ovf_drained", fifo_count, 0);

        // Pop coincides with the push of a third message while full.
        sb.push_back(24'h444444);
        sb.push_back(24'h555555);
        sb.push_back(24'h666666);
        send_msg(24'h444444);
        repeat (5) tick();
        send_msg(24'h555555);
        repeat (5) tick();
        send_msg(24'h666666);
        tick();
        tick();
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("simul_count", fifo_count, 2);
        repeat (3) tick();
        chk("simul_no_ovf", n_ovf, 1);
        chk("simul_head", msg_data, 24'h555555);
        msg_ready = 1'b1;
        wait_drain();
        msg_ready = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a message, with a message buffered.
        send_msg(24'hABCDEF);
        repeat (5) tick();
        chk("pre_rst_valid", msg_valid, 1);
        send_bits(32'hFFF, 12, 40, 12, 12);
        repeat (6) tick();
        line_in = 1'b1;
        repeat (5) tick();
        reset   = 1'b1;
        line_in = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", msg_valid, 0);
        chk("mid_rst_data", msg_data, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_ferr", frame_err, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        msg_ready = 1'b1;
        sb.push_back(24'hC0FFEE);
        send_msg(24'hC0FFEE);
        repeat (6) tick();
        wait_drain();
        msg_ready = 1'b0;
        repeat (5) tick();
        chk("final_ferr", n_ferr, 2);
        chk("final_ovf", n_ovf, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_msg_receiver
`default_nettype wire

// File: doc/pulse_msg_receiver.md
# pulse_msg_receiver

Parametrised pulse-width-coded serial message receiver with a small output FIFO. Decodes a single-wire stream in which each bit is one high pulse: a long pulse is a 1, a short pulse is a 0. Assembles fixed-length messages, detects framing errors and buffers completed messages behind a valid/ready interface. Sits between the inter-board input pin and the game-side message decoder, and replaces the single-message, ack-based receiver.

## Interface

Parameters:
- MSG_BITS, 24: bits per message.
- BIT_THRESH, 26: high-pulse length in cycles. A pulse longer than this decodes as 1; equal or shorter decodes as 0.
- MAX_HIGH, 60: a high pulse longer than this is a framing error.
- GAP_TIMEOUT, 63: low cycles inside a partial message that abort the message.
- FIFO_DEPTH, 2: buffered messages, power of two, ≥2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- line_in  in  1  raw serial input, asynchronous to clock.
- msg_data  out  MSG_BITS  head-of-FIFO message. The first received bit is the MSB.
- msg_valid  out  1  FIFO not empty.
- msg_ready  in  1  consumer accepts msg_data when msg_valid & msg_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  messages held.
- overflow  out  1  one-cycle pulse: a complete message was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: a partial message was discarded.

## Operation

- line_in passes through a 2-flop synchronizer; the result is line_s. All decoding uses line_s and its previous value.
- Counters:
  - hi_cnt counts consecutive high cycles and saturates at MAX_HIGH+1.
  - lo_cnt counts consecutive low cycles and saturates at GAP_TIMEOUT.
  - bit_cnt counts decoded bits, 0..MSG_BITS.
- Bits shift left into shift_reg. The new bit enters at the LSB.
- FSM states:
  - IDLE: bit_cnt=0. A rising edge of line_s goes to HIGH, with hi_cnt starting at 1.
  - HIGH: hi_cnt increments while line_s=1. On the falling edge:
    - If hi_cnt > MAX_HIGH: raise frame_err, clear bit_cnt, go to IDLE.
    - Otherwise: shift in bit (hi_cnt > BIT_THRESH), increment bit_cnt.
    - If that bit was bit MSG_BITS: push {shift_reg, bit} to the FIFO, clear bit_cnt, go to IDLE.
    - Else: go to LOW, with lo_cnt starting at 1.
  - LOW: a rising edge goes to HIGH. If lo_cnt reaches GAP_TIMEOUT: raise frame_err, clear bit_cnt, go to IDLE.
- A saturated long high pulse stays in HIGH until it falls. The error is reported at the falling edge.
- FIFO full at push time: the message is dropped, overflow pulses, and the FIFO contents are unchanged.
- Push and pop in the same cycle while full: the pop frees the slot, the push is accepted, and there is no overflow.
- Push and pop in the same cycle while empty: the push is stored and msg_valid rises next cycle. There is no bypass.
- Reset mid-message discards all partial state.

## Timing

- Reset values:
  - msg_valid=0, msg_data=0, fifo_count=0, overflow=0, frame_err=0.
  - FSM=IDLE, all counters 0, synchronizer flops 0.
- A line_in edge reaches the FSM 2 cycles later, on line_s.
- The bit decision and shift happen in the cycle line_s is first seen low after a pulse.
- Push latency: the FIFO write occurs at the clock edge ending the final falling-edge cycle. msg_valid and msg_data are visible the following cycle.
- overflow and frame_err are registered and high for exactly one cycle.
- Pop: when msg_valid & msg_ready at an edge, the head advances, and msg_data and msg_valid update the next cycle.
- msg_data is stable while msg_valid=1 and msg_ready=0.
- Back-to-back messages: a new message's first rising edge may arrive one cycle after the previous message's final falling edge.

## Structure

- Package pulse_rx_pkg holds:
  - the FSM state enum rx_state_t (IDLE, HIGH, LOW);
  - default parameter constants;
  - a helper function computing counter widths via $clog2.
- Sub-module msg_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports push, push_data, full, pop, head_data, empty, count;
  - read and write pointers one bit wider than the address for the full/empty distinction.
- Top level contains the synchronizer, counters, FSM and shift register.

## Test plan

- Default parameters, one 24-bit message 0xA5C3F0, with 1-bits as 40-cycle pulses, 0-bits as 12-cycle pulses and 12-cycle gaps. Hold msg_ready=0. Expect msg_data=0xA5C3F0 and msg_valid=1 exactly 3 cycles after the final line_in fall, with fifo_count=1.
- Threshold edges: pulses of 26 and 27 cycles. Expect decoded bits 0 and 1. A 61-cycle pulse gives a frame_err pulse and no push.
- Send 10 bits, then hold low 63 cycles. Expect one frame_err pulse. A following valid message 0x000001 decodes correctly.
- With msg_ready=0, send 3 messages (0x111111, 0x222222, 0x333333). Expect fifo_count=2, one overflow pulse on the third, and pops returning 0x111111 then 0x222222.
- FIFO full, with msg_ready asserted in the same cycle as the third message's push. Expect no overflow, fifo_count stays 2, and order is preserved.
- Assert reset mid-message after 12 bits. Expect all outputs 0. The next full message decodes without corruption.
